// File: rtl/switchbox_cfg_pkg.sv
// Shared types and constants for the switch box configuration loader.
// Optional readback (rb_addr/rb_data) is enabled with CFG_READBACK_EN.
package switchbox_cfg_pkg;

   localparam int unsigned NTB    = 5;
   localparam int unsigned NLR    = 4;
   localparam int unsigned ENT_W  = 6;
   localparam int unsigned N      = 2*NTB + 2*NLR;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned SIDE_W = 3;
   localparam int unsigned IDX_W  = 3;
   localparam int unsigned BUS_W  = N*ENT_W;

   localparam logic [SIDE_W-1:0] SIDE_NONE   = 3'd0;
   localparam logic [SIDE_W-1:0] SIDE_TOP    = 3'd1;
   localparam logic [SIDE_W-1:0] SIDE_RIGHT  = 3'd2;
   localparam logic [SIDE_W-1:0] SIDE_BOTTOM = 3'd3;
   localparam logic [SIDE_W-1:0] SIDE_LEFT   = 3'd4;

   localparam int unsigned TOP_BASE    = 0;
   localparam int unsigned BOTTOM_BASE = NTB;
   localparam int unsigned LEFT_BASE   = 2*NTB;
   localparam int unsigned RIGHT_BASE  = 2*NTB + NLR;

   typedef enum logic [1:0] {IDLE, LOAD, CHECK, COMMIT} state_t;

   // Route entry layout: [5:3] source index, [2:0] source side
   typedef struct packed {
      logic [IDX_W-1:0]  idx;
      logic [SIDE_W-1:0] side;
   } route_t;

   // Side and index of the wire that owns a given entry address
   function automatic route_t addr_to_side(input logic [ADDR_W-1:0] addr);
      route_t r;
      if (addr < ADDR_W'(BOTTOM_BASE)) begin
         r.side = SIDE_TOP;
         r.idx  = IDX_W'(addr - ADDR_W'(TOP_BASE));
      end else if (addr < ADDR_W'(LEFT_BASE)) begin
         r.side = SIDE_BOTTOM;
         r.idx  = IDX_W'(addr - ADDR_W'(BOTTOM_BASE));
      end else if (addr < ADDR_W'(RIGHT_BASE)) begin
         r.side = SIDE_LEFT;
         r.idx  = IDX_W'(addr - ADDR_W'(LEFT_BASE));
      end else begin
         r.side = SIDE_RIGHT;
         r.idx  = IDX_W'(addr - ADDR_W'(RIGHT_BASE));
      end
      return r;
   endfunction

endpackage

// File: rtl/switchbox_cfg_ctrl_if.sv
// Configuration stream and active-config bus between host and loader.
// Readback signals exist only when CFG_READBACK_EN is defined.
interface switchbox_cfg_ctrl_if;
   import switchbox_cfg_pkg::*;

   logic             cfg_start;
   logic             cfg_clear;
   logic             cfg_valid;
   logic [ENT_W-1:0] cfg_data;
   logic             cfg_ready;
   logic             busy;
   logic             cfg_done;
   logic             cfg_err;
   logic [BUS_W-1:0] cfg_bus;
`ifdef CFG_READBACK_EN
   logic [ADDR_W-1:0] rb_addr;
   logic [ENT_W-1:0]  rb_data;

   modport master (output cfg_start, cfg_clear, cfg_valid, cfg_data, rb_addr,
                   input  cfg_ready, busy, cfg_done, cfg_err, cfg_bus, rb_data);
   modport slave  (input  cfg_start, cfg_clear, cfg_valid, cfg_data, rb_addr,
                   output cfg_ready, busy, cfg_done, cfg_err, cfg_bus, rb_data);
`else
   modport master (output cfg_start, cfg_clear, cfg_valid, cfg_data,
                   input  cfg_ready, busy, cfg_done, cfg_err, cfg_bus);
   modport slave  (input  cfg_start, cfg_clear, cfg_valid, cfg_data,
                   output cfg_ready, busy, cfg_done, cfg_err, cfg_bus);
`endif
endinterface

// File: rtl/switchbox_entry_chk.sv
// Legality check of one route entry against the wire it drives.
module switchbox_entry_chk
   import switchbox_cfg_pkg::*;
(
   input  logic [ENT_W-1:0]  entry,
   input  logic [ADDR_W-1:0] own_addr,
   output logic              illegal
);

   route_t ent;
   route_t own;

   always_comb begin
      ent     = route_t'(entry);
      own     = addr_to_side(own_addr);
      illegal = 1'b0;
      case (ent.side)
         SIDE_NONE:              illegal = 1'b0;
         SIDE_TOP, SIDE_BOTTOM:  illegal = (ent.idx >= IDX_W'(NTB));
         SIDE_RIGHT, SIDE_LEFT:  illegal = (ent.idx >= IDX_W'(NLR));
         default:                illegal = 1'b1;
      endcase
      // A wire may not be sourced from itself
      if (ent.side != SIDE_NONE && ent == own) illegal = 1'b1;
   end

endmodule

// File: rtl/switchbox_cfg_ctrl.sv
// Loads a route frame into a shadow store, checks it, and commits it only if clean.
// Define CFG_READBACK_EN to add the registered active-entry readback port.
module switchbox_cfg_ctrl
   import switchbox_cfg_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   switchbox_cfg_ctrl_if.slave  ifc
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] chk_q, chk_d;
   logic              err_q, err_d;
   logic [ENT_W-1:0]  shadow_q [N];
   logic [ENT_W-1:0]  shadow_d [N];
   logic [ENT_W-1:0]  bus_q [N];
   logic [ENT_W-1:0]  bus_d [N];
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              cerr_q, cerr_d;
   logic              illegal;

   switchbox_entry_chk u_entry_chk (
      .entry    (shadow_q[chk_q]),
      .own_addr (chk_q),
      .illegal  (illegal)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         chk_q   <= '0;
         err_q   <= 1'b0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cerr_q  <= 1'b0;
         for (int k = 0; k < int'(N); k++) begin
            shadow_q[k] <= '0;
            bus_q[k]    <= '0;
         end
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         chk_q    <= chk_d;
         err_q    <= err_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         cerr_q   <= cerr_d;
         shadow_q <= shadow_d;
         bus_q    <= bus_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      chk_d    = chk_q;
      err_d    = err_q;
      shadow_d = shadow_q;
      bus_d    = bus_q;
      done_d   = 1'b0;
      cerr_d   = cerr_q;
      case (state_q)
         IDLE: begin
            if (ifc.cfg_start) begin
               state_d = LOAD;
               addr_d  = '0;
               err_d   = 1'b0;
               cerr_d  = 1'b0;
            end else if (ifc.cfg_clear) begin
               for (int k = 0; k < int'(N); k++) bus_d[k] = '0;
            end
         end
         LOAD: begin
            // A restart wins over any beat presented in the same cycle
            if (ifc.cfg_start) begin
               addr_d = '0;
            end else if (ifc.cfg_valid && ready_q) begin
               shadow_d[addr_q] = ifc.cfg_data;
               if (addr_q == ADDR_W'(N-1)) begin
                  state_d = CHECK;
                  chk_d   = '0;
               end else begin
                  addr_d = addr_q + ADDR_W'(1);
               end
            end
         end
         CHECK: begin
            if (illegal) err_d = 1'b1;
            if (chk_q == ADDR_W'(N-1)) state_d = COMMIT;
            else                       chk_d   = chk_q + ADDR_W'(1);
         end
         COMMIT: begin
            state_d = IDLE;
            if (err_q) begin
               cerr_d = 1'b1;
            end else begin
               bus_d  = shadow_q;
               done_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      ready_d = (state_d == LOAD);
      busy_d  = (state_d != IDLE);
   end

   assign ifc.cfg_ready = ready_q;
   assign ifc.busy      = busy_q;
   assign ifc.cfg_done  = done_q;
   assign ifc.cfg_err   = cerr_q;

   for (genvar g = 0; g < int'(N); g++) begin : g_bus
      assign ifc.cfg_bus[g*ENT_W +: ENT_W] = bus_q[g];
   end

`ifdef CFG_READBACK_EN
   logic [ENT_W-1:0] rb_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           rb_q <= '0;
      else if (ifc.rb_addr < ADDR_W'(N))    rb_q <= bus_q[ifc.rb_addr];
      else                                  rb_q <= '0;
   end

   assign ifc.rb_data = rb_q;
`endif

endmodule

// File: tb/tb_switchbox_cfg_ctrl.sv
// Randomized scoreboard bench for switchbox_cfg_ctrl against a frame-level model.
module tb_switchbox_cfg_ctrl;
   import switchbox_cfg_pkg::*;

   localparam int unsigned FW = N*ENT_W;

   typedef struct {
      bit            ok;
      logic [FW-1:0] bus;
      int            cyc;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   checks;
   int   failures;

   exp_t          sbq[$];
   logic [FW-1:0] model_bus;
   logic [5:0]    fr [N];

   switchbox_cfg_ctrl_if ifc();

   switchbox_cfg_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ifc   (ifc.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference rules: owner wire from the address map, then side/index legality
   function automatic bit entry_ok(input int k, input logic [5:0] e);
      int side;
      int idx;
      int own_side;
      int own_idx;
      side = int'(e[2:0]);
      idx  = int'(e[5:3]);
      if (k < 5)       begin own_side = 1; own_idx = k;      end
      else if (k < 10) begin own_side = 3; own_idx = k - 5;  end
      else if (k < 14) begin own_side = 4; own_idx = k - 10; end
      else             begin own_side = 2; own_idx = k - 14; end
      if (side == 0) return 1'b1;
      if (side > 4) return 1'b0;
      if ((side == 1 || side == 3) && idx >= 5) return 1'b0;
      if ((side == 2 || side == 4) && idx >= 4) return 1'b0;
      return !(side == own_side && idx == own_idx);
   endfunction

   function automatic bit frame_ok();
      for (int k = 0; k < int'(N); k++)
         if (!entry_ok(k, fr[k])) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [FW-1:0] pack_frame();
      logic [FW-1:0] p;
      p = '0;
      for (int k = int'(N) - 1; k >= 0; k--) p = (p << ENT_W) | FW'(fr[k]);
      return p;
   endfunction

   task automatic clear_frame();
      for (int k = 0; k < int'(N); k++) fr[k] = 6'd0;
   endtask

   task automatic rand_frame(input int bad_pct);
      int s;
      for (int k = 0; k < int'(N); k++) begin
         s = int'($urandom_range(0, 4));
         fr[k][2:0] = 3'(s);
         fr[k][5:3] = 3'($urandom_range(0, (s == 1 || s == 3) ? 4 : 3));
         if (int'($urandom_range(0, 99)) < bad_pct) fr[k] = 6'($urandom);
      end
   endtask

   task automatic legal_frame();
      int tries;
      tries = 0;
      rand_frame(0);
      while (!frame_ok() && tries < 50) begin
         rand_frame(0);
         tries++;
      end
      if (!frame_ok()) clear_frame();
      fr[0] = 6'b000_010;
   endtask

   // Start pulse (with a random stray beat), then nbeats of fr; mode 0 always valid, 1 alternate, 2 random
   task automatic send_frame(input int mode, input int nbeats, input bit push);
      int k;
      int budget;
      bit v;
      bit acc;
      bit legal;
      k = 0;
      budget = 0;
      ifc.cfg_start = 1'b1;
      ifc.cfg_valid = 1'($urandom_range(0, 1));
      ifc.cfg_data  = 6'($urandom);
      @(negedge clk);
      ifc.cfg_start = 1'b0;
      while (k < nbeats && budget < 400) begin
         case (mode)
            1:       v = (budget % 2) == 0;
            2:       v = 1'($urandom_range(0, 1));
            default: v = 1'b1;
         endcase
         ifc.cfg_valid = v;
         ifc.cfg_data  = v ? fr[k] : 6'($urandom);
         acc = v && ifc.cfg_ready;
         @(negedge clk);
         if (acc) k++;
         budget++;
      end
      ifc.cfg_valid = 1'b0;
      chk("beats_accepted", FW'(k), FW'(nbeats));
      if (push && k == int'(N)) begin
         legal = frame_ok();
         if (legal) model_bus = pack_frame();
         sbq.push_back('{ok: legal, bus: model_bus, cyc: cyc + int'(N) + 1});
      end
   endtask

   task automatic wait_idle();
      int budget;
      budget = 0;
      while (ifc.busy && budget < 100) begin
         @(negedge clk);
         budget++;
      end
      chk("idle_reached", FW'(ifc.busy), FW'(0));
   endtask

   // Monitor: each cfg_done or cfg_err rise consumes one expected frame outcome
   initial begin : monitor
      bit   err_prev;
      exp_t e;
      err_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            err_prev = 1'b0;
         end else begin
            if (ifc.cfg_done || (ifc.cfg_err && !err_prev)) begin
               if (sbq.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_event actual=done%0d/err%0d required=none",
                           ifc.cfg_done, ifc.cfg_err);
               end else begin
                  e = sbq.pop_front();
                  chk("commit_done", FW'(ifc.cfg_done), FW'(e.ok));
                  chk("commit_err", FW'(ifc.cfg_err), FW'(!e.ok));
                  chk("commit_bus", ifc.cfg_bus, e.bus);
                  chk("commit_cycle", FW'(cyc), FW'(e.cyc));
               end
            end
            err_prev = ifc.cfg_err;
         end
      end
   end

   initial begin
      checks = 0;
      failures = 0;
      cyc = 0;
      model_bus = '0;
      rst_n = 1'b0;
      ifc.cfg_start = 1'b0;
      ifc.cfg_clear = 1'b0;
      ifc.cfg_valid = 1'b0;
      ifc.cfg_data  = '0;
`ifdef CFG_READBACK_EN
      ifc.rb_addr = '0;
`endif
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_busy",  FW'(ifc.busy), FW'(0));
      chk("reset_ready", FW'(ifc.cfg_ready), FW'(0));
      chk("reset_done",  FW'(ifc.cfg_done), FW'(0));
      chk("reset_err",   FW'(ifc.cfg_err), FW'(0));
      chk("reset_bus",   ifc.cfg_bus, FW'(0));

      // Single legal entry top0 <- right0
      clear_frame();
      fr[0] = 6'b000_010;
      send_frame(0, N, 1);
      wait_idle();
      chk("t1_err", FW'(ifc.cfg_err), FW'(0));
      chk("t1_entry0", FW'(ifc.cfg_bus[5:0]), FW'(6'h02));
`ifdef CFG_READBACK_EN
      ifc.rb_addr = 5'd0;
      @(negedge clk);
      chk("rb_addr0", FW'(ifc.rb_data), FW'(6'h02));
      ifc.rb_addr = 5'd20;
      @(negedge clk);
      chk("rb_addr20", FW'(ifc.rb_data), FW'(0));
`endif

      // Self-loop on right0
      clear_frame();
      fr[14] = 6'b000_010;
      send_frame(0, N, 1);
      wait_idle();
      chk("t2_err", FW'(ifc.cfg_err), FW'(1));
      chk("t2_bus_held", ifc.cfg_bus, model_bus);

      // Out-of-range left index, then bottom4 which is in range
      clear_frame();
      fr[10] = 6'b100_100;
      send_frame(2, N, 1);
      wait_idle();
      chk("t3_err", FW'(ifc.cfg_err), FW'(1));
      clear_frame();
      fr[0] = 6'b100_011;
      send_frame(0, N, 1);
      wait_idle();
      chk("t3_ok_err", FW'(ifc.cfg_err), FW'(0));
      chk("t3_ok_entry0", FW'(ifc.cfg_bus[5:0]), FW'(6'b100_011));

      // Restart after 7 beats; only the second frame lands
      legal_frame();
      fr[1] = 6'b000_001;
      send_frame(0, 7, 0);
      legal_frame();
      send_frame(0, N, 1);
      wait_idle();
      chk("t4_bus", ifc.cfg_bus, model_bus);

      // Side 5 with a gappy stream, then clear in IDLE
      clear_frame();
      fr[3] = 6'b000_101;
      send_frame(1, N, 1);
      wait_idle();
      chk("t5_err", FW'(ifc.cfg_err), FW'(1));
      ifc.cfg_clear = 1'b1;
      @(negedge clk);
      ifc.cfg_clear = 1'b0;
      model_bus = '0;
      chk("t5_clear_bus", ifc.cfg_bus, FW'(0));
      chk("t5_err_sticky", FW'(ifc.cfg_err), FW'(1));
      legal_frame();
      send_frame(0, N, 1);
      wait_idle();

      // Clear held for the whole busy period must not touch the bus
      ifc.cfg_clear = 1'b1;
      rand_frame(3);
      send_frame(2, N, 1);
      wait_idle();
      ifc.cfg_clear = 1'b0;
      @(negedge clk);
      chk("t5_clear_busy", ifc.cfg_bus, model_bus);

      // Random frames, mixed legality and stream patterns
      for (int i = 0; i < 8; i++) begin
         rand_frame(2);
         send_frame(int'($urandom_range(0, 2)), N, 1);
         wait_idle();
      end

      // Reset during CHECK
      legal_frame();
      send_frame(0, N, 0);
      repeat (5) @(negedge clk);
      chk("t6_busy_before", FW'(ifc.busy), FW'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("t6_busy",  FW'(ifc.busy), FW'(0));
      chk("t6_ready", FW'(ifc.cfg_ready), FW'(0));
      chk("t6_done",  FW'(ifc.cfg_done), FW'(0));
      chk("t6_err",   FW'(ifc.cfg_err), FW'(0));
      chk("t6_bus",   ifc.cfg_bus, FW'(0));
      model_bus = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      legal_frame();
      send_frame(2, N, 1);
      wait_idle();
`ifdef CFG_READBACK_EN
      for (int i = 0; i < 8; i++) begin
         int a;
         a = int'($urandom_range(0, 31));
         ifc.rb_addr = 5'(a);
         @(negedge clk);
         chk("rb_random", FW'(ifc.rb_data),
             (a < int'(N)) ? FW'(6'(model_bus >> (a*int'(ENT_W)))) : FW'(0));
      end
`endif
      repeat (30) @(negedge clk);
      chk("scoreboard_drained", FW'(sbq.size()), FW'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
